// File: rtl/s4ga_pkg.sv
// Shared sizing for the s4ga serial LUT fabric: derived widths, frame length
// and bit offsets of the select and truth-table fields within one frame.
package s4ga_pkg;

    localparam int N    = 16;
    localparam int K    = 4;
    localparam int SI_W = 4;

    localparam int I_W     = $clog2(N);
    localparam int TT_W    = 2 ** K;
    localparam int SEL_W   = K * I_W;
    localparam int FRAME_W = SEL_W + TT_W;
    localparam int F       = FRAME_W / SI_W;
    // The last nibble is used straight off the bus, so only F-1 nibbles are held.
    localparam int ACC_W   = FRAME_W - SI_W;

    localparam int SEL_OFS = 0;
    localparam int TT_OFS  = SEL_W;

    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PH_W = ctr_width(F);

endpackage

// File: rtl/s4ga_lut.sv
// Combinational K-input LUT: picks K bits of the LUT-state vector and uses
// them (select 0 as LSB) to index the streamed truth table.
module s4ga_lut
    import s4ga_pkg::*;
(
    input  logic [N-1:0]     luts_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic [TT_W-1:0]  tt_i,
    output logic             y_o
);

    logic [K-1:0] idx;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_idx
            assign idx[gi] = luts_i[sel_i[gi*I_W +: I_W]];
        end
    endgenerate

    assign y_o = tt_i[idx];

endmodule

// File: rtl/s4ga_fabric.sv
// Time-multiplexed LUT fabric top: frames stream in on si, one LUT per frame.
// Define S4GA_OUT_SYNC_EN to register io_out once per full pass.
module s4ga_fabric (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    import s4ga_pkg::*;

    logic            clk;
    logic            rst;
    logic [SI_W-1:0] si;
    logic            unused_reserved;

    assign clk             = io_in[0];
    assign rst             = io_in[1];
    assign si              = io_in[SI_W+1:2];
    assign unused_reserved = ^io_in[7:SI_W+2];

    logic [PH_W-1:0]    phase_q, phase_d;
    logic [I_W-1:0]     lut_q, lut_d;
    logic [N-1:0]       luts_q, luts_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [FRAME_W-1:0] frame;
    logic               last;
    logic               lut_y;

    assign last  = (phase_q == PH_W'(F - 1));
    assign frame = {si, acc_q};

    // Each held nibble slot is overwritten in its own phase, so no clearing between frames.
    generate
        for (genvar gi = 0; gi < F - 1; gi++) begin : g_acc
            assign acc_d[gi*SI_W +: SI_W] = (phase_q == PH_W'(gi)) ? si : acc_q[gi*SI_W +: SI_W];
        end
    endgenerate

    s4ga_lut u_lut (
        .luts_i (luts_q),
        .sel_i  (frame[SEL_OFS +: SEL_W]),
        .tt_i   (frame[TT_OFS +: TT_W]),
        .y_o    (lut_y)
    );

    always_comb begin
        phase_d = last ? '0 : phase_q + 1'b1;
        lut_d   = last ? lut_q + 1'b1 : lut_q;
        luts_d  = luts_q;
        if (last) begin
            luts_d[lut_q] = lut_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            lut_q   <= '0;
            luts_q  <= '0;
            acc_q   <= '0;
        end else begin
            phase_q <= phase_d;
            lut_q   <= lut_d;
            luts_q  <= luts_d;
            acc_q   <= acc_d;
        end
    end

`ifdef S4GA_OUT_SYNC_EN
    logic [7:0] out_q, out_d;

    // Capture at the final LUT update of a pass so all eight outputs move together.
    always_comb begin
        out_d = out_q;
        if (last && (lut_q == I_W'(N - 1))) begin
            out_d = luts_d[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign io_out = out_q;
`else
    assign io_out = luts_q[7:0];
`endif

endmodule

// File: tb/tb_s4ga_fabric.sv
// Directed self-checking bench for s4ga_fabric; expectations adapt when
// S4GA_OUT_SYNC_EN is defined (outputs only move at pass boundaries).
module tb_s4ga_fabric;

`ifdef S4GA_OUT_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] si  = 4'h0;
    logic [7:0] io_out;
    logic [7:0] io_in;

    int checks   = 0;
    int failures = 0;

    logic [15:0] cfg_sel [16];
    logic [15:0] cfg_tt  [16];

    assign io_in = {2'b11, si, rst, clk};

    always #5 clk = ~clk;

    s4ga_fabric dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    task automatic chk(input string tag, input logic [7:0] exp);
        checks++;
        assert (io_out === exp)
        else begin
            failures++;
            $error("FAIL %s: io_out=%h expected=%h", tag, io_out, exp);
        end
        $display("check %-18s io_out=%h expected=%h", tag, io_out, exp);
    endtask

    task automatic send_nib(input logic [3:0] n);
        si = n;
        @(posedge clk);
        #1;
    endtask

    task automatic send_lut(input int i);
        logic [15:0] s;
        logic [15:0] t;
        s = cfg_sel[i];
        t = cfg_tt[i];
        for (int p = 0; p < 4; p++) send_nib(s[4*p +: 4]);
        for (int j = 0; j < 4; j++) send_nib(t[4*j +: 4]);
    endtask

    task automatic send_rest(input int from);
        for (int i = from; i < 16; i++) send_lut(i);
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) begin
            cfg_sel[i] = 16'h0000;
            cfg_tt[i]  = 16'h0000;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        si  = 4'hA;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clear_cfg();

        // Reset with junk on si
        rst = 1'b1;
        si  = 4'h5;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 8'h00);
        rst = 1'b0;

        // Constant one in LUT0
        cfg_tt[0] = 16'hFFFF;
        send_lut(0);
        chk("const_c8", SYNC ? 8'h00 : 8'h01);
        send_lut(1);
        chk("const_c16", SYNC ? 8'h00 : 8'h01);
        send_rest(2);
        chk("const_c128", 8'h01);
        send_lut(0);
        chk("const_c136", 8'h01);
        send_rest(1);
        chk("const_c256", 8'h01);

        // Oscillator: LUT0 inverts itself each pass
        do_reset();
        clear_cfg();
        cfg_tt[0] = 16'h0001;
        send_lut(0);
        chk("osc_c8", SYNC ? 8'h00 : 8'h01);
        send_rest(1);
        chk("osc_c128", 8'h01);
        send_lut(0);
        chk("osc_c136", SYNC ? 8'h01 : 8'h00);
        send_rest(1);
        chk("osc_c256", 8'h00);

        // Chain: LUT1 = AND of LUT0 (evaluated earlier in the pass)
        do_reset();
        clear_cfg();
        cfg_tt[0] = 16'hFFFF;
        cfg_tt[1] = 16'h8000;
        send_lut(0);
        chk("chain_c8", SYNC ? 8'h00 : 8'h01);
        send_lut(1);
        chk("chain_c16", SYNC ? 8'h00 : 8'h03);
        send_rest(2);
        chk("chain_c128", 8'h03);

        // Reverse order: LUT1 reads LUT2, which is evaluated later -> one pass lag
        do_reset();
        clear_cfg();
        cfg_sel[1] = 16'h2222;
        cfg_tt[1]  = 16'h8000;
        cfg_tt[2]  = 16'hFFFF;
        send_lut(0);
        send_lut(1);
        chk("lag_c16", 8'h00);
        send_lut(2);
        chk("lag_c24", SYNC ? 8'h00 : 8'h04);
        send_rest(3);
        chk("lag_c128", 8'h04);
        send_lut(0);
        send_lut(1);
        chk("lag_c144", SYNC ? 8'h04 : 8'h06);
        send_rest(2);
        chk("lag_c256", 8'h06);

        // Select ordering and high selects
        // LUT2 sel=0,1,0,1 -> idx=0101b=5, tt bit5 set -> 1
        // LUT4 sel=1,0,1,0 -> idx=1010b=10, tt bit10 set -> 1
        // LUT5 sel=1,0,1,0 -> idx=10, tt bit10 clear -> 0
        // LUT7 AND of LUT15 (evaluated later) -> 0 then 1
        do_reset();
        clear_cfg();
        cfg_tt[0]  = 16'hFFFF;
        cfg_sel[2] = 16'h1010;
        cfg_tt[2]  = 16'h0020;
        cfg_sel[4] = 16'h0101;
        cfg_tt[4]  = 16'h0400;
        cfg_sel[5] = 16'h0101;
        cfg_tt[5]  = 16'h0020;
        cfg_sel[7] = 16'hFFFF;
        cfg_tt[7]  = 16'h8000;
        cfg_tt[15] = 16'hFFFF;
        send_rest(0);
        chk("sel_c128", 8'h15);
        send_rest(0);
        chk("sel_c256", 8'h95);

        // Mid-frame reset at phase 3 of LUT2
        do_reset();
        clear_cfg();
        cfg_tt[0] = 16'hFFFF;
        cfg_tt[1] = 16'h8000;
        send_rest(0);
        chk("mid_pre_pass", 8'h03);
        send_lut(0);
        send_lut(1);
        send_nib(4'h0);
        send_nib(4'h0);
        send_nib(4'h0);
        rst = 1'b1;
        si  = 4'hF;
        @(posedge clk);
        #1;
        chk("mid_reset", 8'h00);
        rst = 1'b0;
        cfg_tt[1] = 16'h0000;
        send_lut(0);
        chk("mid_after_c8", SYNC ? 8'h00 : 8'h01);
        send_rest(1);
        chk("mid_after_c128", 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
